bcd_source_selector: RTL and testbench
======================================

// Module: bcd_source_selector
// PURPOSE
//  Parametrised N-source, M-digit BCD display selector feeding the 7-segment scan driver.
//  Chooses one of NUM_SRC BCD readouts (note, song, tempo, volume, ...) manually, or
//  rotates through the valid sources on a dwell timer. Registers the chosen digits and
//  applies invalid-digit and leading-zero blanking. Sits between the tone/song
//  counters' binary-to-BCD converters and the seven-segment display driver.
// PARAMETERS
//  NUM_SRC       4            number of BCD sources (>=2)
//  NUM_DIGITS    4            digits per source (>=1)
//  DWELL_CYCLES  100_000_000  auto-mode dwell per source in clk cycles (1 s @ 100 MHz), >=2
//  SEL_W         $clog2(NUM_SRC)  width of source index (localparam-derived)
// PORTS
//  clk          in   1                       system clock
//  reset        in   1                       asynchronous, active-high reset
//  src_bcd      in   NUM_SRC*NUM_DIGITS*4    source s, digit d at [(s*NUM_DIGITS+d)*4 +: 4]; d=0 is ones
//  src_valid    in   NUM_SRC                 source s currently has meaningful data
//  mode_auto    in   1                       1 = timed rotation, 0 = manual select
//  sel_manual   in   SEL_W                   requested source in manual mode
//  blank_lz     in   1                       enable leading-zero blanking
//  digits       out  NUM_DIGITS*4            registered BCD digits of the active source
//  digit_blank  out  NUM_DIGITS              1 = driver must blank this digit
//  active_src   out  SEL_W                   index of the source being displayed
//  switch_pulse out  1                       one-cycle pulse when active_src changes
// BEHAVIOUR
//  - Reset (async, active-high): active_src=0, digits=0, digit_blank=0, switch_pulse=0, dwell counter=0.
//  - Manual (mode_auto=0): if sel_manual<NUM_SRC and src_valid[sel_manual], active_src<=sel_manual
//    next edge; otherwise active_src holds. Dwell counter held at 0.
//  - Auto (mode_auto=1): dwell counter increments each cycle; at DWELL_CYCLES-1 it clears and
//    active_src advances to the next valid index after the current one, wrapping NUM_SRC-1 -> 0.
//    No valid source: active_src holds, counter still wraps.
//  - Auto, current source drops valid: advance on the next edge without waiting for dwell; counter clears.
//  - Entering auto (mode_auto 0->1): counter clears; active_src unchanged on that edge.
//  - Mode deassert coincident with dwell expiry: manual rule wins.
//  - switch_pulse=1 for exactly the cycle after active_src takes a new value; never on same-value writes.
//  - Data path: digits/digit_blank register the slice of src_bcd selected by the current
//    active_src register -> 1-cycle latency from src_bcd, 2 cycles from a select change.
//  - Nibble >9: digits field <= BCD_BLANK (4'hF), digit_blank bit=1.
//  - Leading-zero blanking (blank_lz=1): scan from digit NUM_DIGITS-1 down; each 0 digit is blanked
//    until the first non-zero digit; digit 0 is never blanked for LZ (value 0 shows "0").
//    Blanked-zero digits keep value 0 in digits. blank_lz=0 disables only this rule.
//  - All outputs are registers; no combinational path from inputs to outputs.
// STRUCTURE
//  - Package bcd_disp_pkg: BCD_W=4, BCD_BLANK=4'hF, BCD_MAX=4'd9, function is_bcd_digit().
//  - Sub-module next_valid_src #(NUM_SRC): combinational round-robin finder; inputs cur, valid
//    mask; outputs nxt and found. Used by the auto-advance and drop-out paths.
//  - Top: select FSM (MANUAL/AUTO implicit by mode_auto), dwell counter, output register stage.
// TESTING
//  1. Reset mid-rotation at src 2 -> next cycle active_src=0, digits=0, digit_blank=0, switch_pulse=0.
//  2. Manual, valid=4'b1111, sel_manual 0->3 -> active_src=3 one edge later, switch_pulse one cycle,
//     digits = source-3 value on the following edge.
//  3. Manual, sel_manual=2 with src_valid[2]=0 -> active_src holds 0, no switch_pulse.
//  4. Auto, DWELL_CYCLES=8, valid=4'b1011 -> sequence 0,1,3,0 each held 8 cycles (2 skipped).
//  5. Auto at src 1, drop src_valid[1] mid-dwell -> active_src=3 next edge, counter restarts.
//  6. blank_lz=1, source BCD 0,0,4,0 (thou..ones) -> digit_blank=4'b1100; value 0000 -> 4'b1110;
//     nibble 4'hB in tens -> digits tens=4'hF, digit_blank[1]=1.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: shared BCD display constants and the valid-digit test
package bcd_disp_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  function automatic logic is_bcd_digit(input logic [BCD_W-1:0] n);
    return n <= BCD_MAX;
  endfunction
endpackage

// File: rtl/next_valid_src.sv
// next_valid_src: round-robin search for the next valid source after cur (ports: cur, valid -> nxt, found)
module next_valid_src #(
  parameter int NUM_SRC = 4,
  localparam int SEL_W = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]   cur,
  input  logic [NUM_SRC-1:0] valid,
  output logic [SEL_W-1:0]   nxt,
  output logic               found
);
  // Scanning from the farthest offset down lets the nearest valid index win; offset NUM_SRC is cur itself.
  always_comb begin
    nxt = cur;
    found = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (valid[(int'(cur) + k) % NUM_SRC]) begin
        nxt = SEL_W'((int'(cur) + k) % NUM_SRC);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_source_selector.sv
// bcd_source_selector: picks one of NUM_SRC BCD readouts (manual or timed rotation) and registers its blanked digits
// ports: clk, reset (async high), src_bcd/src_valid sources, mode_auto, sel_manual, blank_lz ->
//        digits, digit_blank, active_src, switch_pulse (all registered)
module bcd_source_selector
  import bcd_disp_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int NUM_DIGITS = 4,
  parameter int DWELL_CYCLES = 100_000_000,
  localparam int SEL_W = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC*NUM_DIGITS*BCD_W-1:0] src_bcd,
  input  logic [NUM_SRC-1:0]                src_valid,
  input  logic                              mode_auto,
  input  logic [SEL_W-1:0]                  sel_manual,
  input  logic                              blank_lz,
  output logic [NUM_DIGITS*BCD_W-1:0]       digits,
  output logic [NUM_DIGITS-1:0]             digit_blank,
  output logic [SEL_W-1:0]                  active_src,
  output logic                              switch_pulse
);
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  logic [SEL_W-1:0] r_active, w_active_nxt, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_mode_d, r_pulse, w_found;
  logic [NUM_DIGITS*BCD_W-1:0] r_digits, w_digits;
  logic [NUM_DIGITS-1:0] r_blank, w_blank;
  next_valid_src #(.NUM_SRC(NUM_SRC)) u_next (
    .cur(r_active),
    .valid(src_valid),
    .nxt(w_nxt),
    .found(w_found)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_active <= '0;
      r_cnt <= '0;
      r_mode_d <= 1'b0;
      r_pulse <= 1'b0;
      r_digits <= '0;
      r_blank <= '0;
    end else begin
      r_active <= w_active_nxt;
      r_cnt <= w_cnt_nxt;
      r_mode_d <= mode_auto;
      r_pulse <= w_active_nxt != r_active;
      r_digits <= w_digits;
      r_blank <= w_blank;
    end
  // Manual mode and the first auto cycle keep the counter at zero; auto advances on expiry or when
  // the shown source drops out, holding if nothing is valid.
  always_comb begin
    w_active_nxt = r_active;
    w_cnt_nxt = '0;
    if (!mode_auto) begin
      if (int'(sel_manual) < NUM_SRC && src_valid[sel_manual]) w_active_nxt = sel_manual;
    end else if (r_mode_d && (!src_valid[r_active] || r_cnt == CNT_W'(DWELL_CYCLES - 1)))
      w_active_nxt = w_found ? w_nxt : r_active;
    else if (r_mode_d)
      w_cnt_nxt = r_cnt + 1'b1;
  end
  // lead stays set while every digit above and including d is zero; digit 0 is never LZ-blanked.
  always_comb begin
    logic lead;
    logic [BCD_W-1:0] n;
    lead = blank_lz;
    n = '0;
    w_digits = '0;
    w_blank = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      n = src_bcd[(int'(r_active) * NUM_DIGITS + d) * BCD_W +: BCD_W];
      lead = lead && n == '0;
      w_digits[d*BCD_W +: BCD_W] = is_bcd_digit(n) ? n : BCD_BLANK;
      w_blank[d] = !is_bcd_digit(n) || (lead && d != 0);
    end
  end
  assign digits = r_digits;
  assign digit_blank = r_blank;
  assign active_src = r_active;
  assign switch_pulse = r_pulse;
endmodule

// File: tb/tb_bcd_source_selector.sv
// tb_bcd_source_selector: directed scenarios plus random stimulus against a behavioural model
module tb_bcd_source_selector;
  localparam int NS = 4, ND = 4, DW = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic [NS*ND*4-1:0] src_bcd = '0;
  logic [NS-1:0] src_valid = '1;
  logic mode_auto = 1'b0, blank_lz = 1'b0;
  logic [1:0] sel_manual = 2'd0;
  logic [ND*4-1:0] digits;
  logic [ND-1:0] digit_blank;
  logic [1:0] active_src;
  logic switch_pulse;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_active = 0, m_cnt = 0;
  bit m_mode = 1'b0;
  int pulse_at[$];
  int pulse_src[$];
  always #5 clk = ~clk;
  bcd_source_selector #(.NUM_SRC(NS), .NUM_DIGITS(ND), .DWELL_CYCLES(DW)) dut (
    .clk(clk), .reset(reset), .src_bcd(src_bcd), .src_valid(src_valid), .mode_auto(mode_auto),
    .sel_manual(sel_manual), .blank_lz(blank_lz), .digits(digits), .digit_blank(digit_blank),
    .active_src(active_src), .switch_pulse(switch_pulse)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int next_after(input int a, input logic [NS-1:0] v);
    for (int k = 1; k <= NS; k++) if (v[(a + k) % NS]) return (a + k) % NS;
    return a;
  endfunction
  function automatic void fmt(input logic [NS*ND*4-1:0] bcd, input int s, input bit lz,
                              output logic [ND*4-1:0] d, output logic [ND-1:0] b);
    int nib[ND];
    int top = -1;
    for (int i = 0; i < ND; i++) begin
      nib[i] = int'(bcd[(s*ND+i)*4 +: 4]);
      if (nib[i] != 0) top = i;
    end
    for (int i = 0; i < ND; i++) begin
      d[i*4 +: 4] = nib[i] > 9 ? 4'hF : 4'(nib[i]);
      b[i] = nib[i] > 9 || (lz && i > top && i > 0);
    end
  endfunction
  task automatic tick();
    logic [ND*4-1:0] ed;
    logic [ND-1:0] eb;
    int na, nc;
    fmt(src_bcd, m_active, blank_lz, ed, eb);
    na = m_active;
    nc = 0;
    if (!mode_auto) na = src_valid[sel_manual] ? int'(sel_manual) : m_active;
    else if (!m_mode) nc = 0;
    else if (!src_valid[m_active]) na = next_after(m_active, src_valid);
    else if (m_cnt + 1 == DW) na = next_after(m_active, src_valid);
    else nc = m_cnt + 1;
    @(posedge clk);
    cyc++;
    #1;
    check("active_src", 32'(active_src), 32'(na));
    check("switch_pulse", 32'(switch_pulse), 32'(na != m_active));
    check("digits", 32'(digits), 32'(ed));
    check("digit_blank", 32'(digit_blank), 32'(eb));
    if (switch_pulse) begin
      pulse_at.push_back(cyc);
      pulse_src.push_back(int'(active_src));
    end
    m_active = na;
    m_cnt = nc;
    m_mode = mode_auto;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_active"}, 32'(active_src), 32'd0);
    check({tag, "_digits"}, 32'(digits), 32'd0);
    check({tag, "_blank"}, 32'(digit_blank), 32'd0);
    check({tag, "_pulse"}, 32'(switch_pulse), 32'd0);
  endtask
  initial begin
    int c0;
    bit hit;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_zero("reset");
    src_bcd[3*16 +: 16] = 16'h1234;
    src_bcd[0 +: 16] = 16'h0567;
    tick();
    sel_manual = 2'd3;
    tick();
    check("t2_active", 32'(active_src), 32'd3);
    check("t2_pulse", 32'(switch_pulse), 32'd1);
    tick();
    check("t2_pulse_off", 32'(switch_pulse), 32'd0);
    check("t2_digits", 32'(digits), 32'h1234);
    sel_manual = 2'd0;
    tick();
    tick();
    src_valid = 4'b1011;
    sel_manual = 2'd2;
    tick();
    check("t3_hold", 32'(active_src), 32'd0);
    check("t3_nopulse", 32'(switch_pulse), 32'd0);
    sel_manual = 2'd0;
    blank_lz = 1'b1;
    src_bcd[0 +: 16] = 16'h0040;
    tick();
    check("t6_lz_blank", 32'(digit_blank), 32'b1100);
    check("t6_lz_digits", 32'(digits), 32'h0040);
    src_bcd[0 +: 16] = 16'h0000;
    tick();
    check("t6_zero_blank", 32'(digit_blank), 32'b1110);
    check("t6_zero_digits", 32'(digits), 32'h0000);
    src_bcd[0 +: 16] = 16'h00B0;
    tick();
    check("t6_bad_digits", 32'(digits), 32'h00F0);
    check("t6_bad_blank", 32'(digit_blank), 32'b1110);
    blank_lz = 1'b0;
    src_bcd[0 +: 16] = 16'h0040;
    tick();
    check("t6_nolz_blank", 32'(digit_blank), 32'b0000);
    mode_auto = 1'b1;
    pulse_at.delete();
    pulse_src.delete();
    c0 = cyc;
    repeat (40) tick();
    check("t4_npulses", 32'(pulse_at.size()), 32'd4);
    if (pulse_at.size() == 4) begin
      check("t4_src0", 32'(pulse_src[0]), 32'd1);
      check("t4_src1", 32'(pulse_src[1]), 32'd3);
      check("t4_src2", 32'(pulse_src[2]), 32'd0);
      check("t4_first", 32'(pulse_at[0] - c0), 32'd9);
      check("t4_dwell1", 32'(pulse_at[1] - pulse_at[0]), 32'd8);
      check("t4_dwell2", 32'(pulse_at[2] - pulse_at[1]), 32'd8);
    end
    src_valid = 4'b1001;
    tick();
    check("t5_drop", 32'(active_src), 32'd3);
    repeat (7) tick();
    check("t5_restart_hold", 32'(active_src), 32'd3);
    tick();
    check("t5_restart_adv", 32'(active_src), 32'd0);
    src_valid = 4'b1111;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      hit = active_src == 2'd2;
    end
    check("t1_reach_src2", 32'(hit), 32'd1);
    #2 reset = 1'b1;
    #1 check_zero("t1_async");
    @(posedge clk);
    #1 reset = 1'b0;
    m_active = 0;
    m_cnt = 0;
    m_mode = 1'b0;
    check_zero("t1_after");
    for (int i = 0; i < 600; i++) begin
      for (int s = 0; s < NS*ND; s++) src_bcd[s*4 +: 4] = ($urandom % 2) ? 4'h0 : 4'($urandom % 16);
      if ($urandom % 16 == 0) src_valid = 4'($urandom);
      if ($urandom % 24 == 0) mode_auto = ~mode_auto;
      sel_manual = 2'($urandom);
      blank_lz = 1'($urandom);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
